// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports with busy flags, writeback
// port A (ALU/load), writeback port B (long-latency mul/div) and the
// reservation request/ready pair with the reserved-register count.
interface reg_file_sb_if #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 32
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);

  logic [AW-1:0]         rs1_address_i;
  logic [DATA_WIDTH-1:0] rs1_data_o;
  logic                  rs1_busy_o;
  logic [AW-1:0]         rs2_address_i;
  logic [DATA_WIDTH-1:0] rs2_data_o;
  logic                  rs2_busy_o;
  logic                  rd_we_i;
  logic [AW-1:0]         rd_address_i;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  lw_we_i;
  logic [AW-1:0]         lw_address_i;
  logic [DATA_WIDTH-1:0] lw_data_i;
  logic                  rsv_valid_i;
  logic [AW-1:0]         rsv_address_i;
  logic                  rsv_ready_o;
  logic [AW:0]           busy_count_o;

  // Requester side: issue/decode/writeback logic.
  modport master (
    output rs1_address_i, rs2_address_i,
    output rd_we_i, rd_address_i, rd_data_i,
    output lw_we_i, lw_address_i, lw_data_i,
    output rsv_valid_i, rsv_address_i,
    input  rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o,
    input  rsv_ready_o, busy_count_o
  );

  // Register file side.
  modport slave (
    input  rs1_address_i, rs2_address_i,
    input  rd_we_i, rd_address_i, rd_data_i,
    input  lw_we_i, lw_address_i, lw_data_i,
    input  rsv_valid_i, rsv_address_i,
    output rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o,
    output rsv_ready_o, busy_count_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with per-register scoreboard.
// Register 0 is hardwired zero. Port B (long-latency writeback) wins over
// port A on an address collision and is the only port that releases a
// reservation. Optional macro REGFILE_BYPASS_EN forwards same-cycle writes
// to the read ports and lets a releasing port B write satisfy a
// reservation in the same cycle.
module reg_file_sb #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 32
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);

  logic [DATA_WIDTH-1:0]          mem [NUMBER_OF_REGISTERS];
  logic [NUMBER_OF_REGISTERS-1:0] busy;
  logic [AW:0]                    busy_count;

  logic a_commit;
  logic b_commit;
  logic set_hit;
  logic clr_hit;

  // Decode which writes, reservations and releases take effect this edge.
  always_comb begin
    a_commit = bus.rd_we_i && (bus.rd_address_i != '0);
    b_commit = bus.lw_we_i && (bus.lw_address_i != '0);
    clr_hit  = bus.lw_we_i && busy[bus.lw_address_i];
    set_hit  = bus.rsv_valid_i && bus.rsv_ready_o && (bus.rsv_address_i != '0);
  end

  // Register storage; port B is assigned last so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++) mem[i] <= '0;
    end else begin
      if (a_commit) mem[bus.rd_address_i] <= bus.rd_data_i;
      if (b_commit) mem[bus.lw_address_i] <= bus.lw_data_i;
    end
  end

  // Scoreboard bits and reserved-register count; a set overrides a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (clr_hit) busy[bus.lw_address_i]  <= 1'b0;
      if (set_hit) busy[bus.rsv_address_i] <= 1'b1;
      case ({set_hit, clr_hit})
        2'b10:   busy_count <= busy_count + 1'b1;
        2'b01:   busy_count <= busy_count - 1'b1;
        default: busy_count <= busy_count;
      endcase
    end
  end

  // Combinational read ports and reservation readiness.
  always_comb begin
    bus.rs1_data_o   = mem[bus.rs1_address_i];
    bus.rs2_data_o   = mem[bus.rs2_address_i];
    bus.rs1_busy_o   = busy[bus.rs1_address_i];
    bus.rs2_busy_o   = busy[bus.rs2_address_i];
    bus.rsv_ready_o  = (bus.rsv_address_i == '0) || !busy[bus.rsv_address_i];
    bus.busy_count_o = busy_count;
`ifdef REGFILE_BYPASS_EN
    if (a_commit && (bus.rd_address_i == bus.rs1_address_i)) bus.rs1_data_o = bus.rd_data_i;
    if (b_commit && (bus.lw_address_i == bus.rs1_address_i)) bus.rs1_data_o = bus.lw_data_i;
    if (a_commit && (bus.rd_address_i == bus.rs2_address_i)) bus.rs2_data_o = bus.rd_data_i;
    if (b_commit && (bus.lw_address_i == bus.rs2_address_i)) bus.rs2_data_o = bus.lw_data_i;
    if (bus.lw_we_i && (bus.lw_address_i == bus.rs1_address_i)) bus.rs1_busy_o = 1'b0;
    if (bus.lw_we_i && (bus.lw_address_i == bus.rs2_address_i)) bus.rs2_busy_o = 1'b0;
    if (clr_hit && (bus.lw_address_i == bus.rsv_address_i)) bus.rsv_ready_o = 1'b1;
`endif
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: expectations are queued as stimulus is
// driven and drained/compared once the DUT should present them.
module tb_reg_file_sb;
  localparam int N  = 32;
  localparam int DW = 32;
  localparam int AW = $clog2(N);

  typedef enum int {K_RD1, K_RD2, K_BSY1, K_RDY, K_CNT} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [AW-1:0] addr;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic rst;
  sb_t  sb_q[$];
  int   n_vec;
  int   n_err;

  reg_file_sb_if #(.NUMBER_OF_REGISTERS(N), .DATA_WIDTH(DW)) bus ();

  reg_file_sb #(.NUMBER_OF_REGISTERS(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_we_i = 1'b0; bus.rd_address_i = '0; bus.rd_data_i = '0;
    bus.lw_we_i = 1'b0; bus.lw_address_i = '0; bus.lw_data_i = '0;
    bus.rsv_valid_i = 1'b0; bus.rsv_address_i = '0;
  endtask

  task automatic expect_v(input string tag, input kind_t k, input int a, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.kind = k; e.addr = AW'(a); e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    logic [AW-1:0] s1, s2, sr;
    logic [31:0]   obs;
    sb_t           e;
    s1 = bus.rs1_address_i; s2 = bus.rs2_address_i; sr = bus.rsv_address_i;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_RD1, K_BSY1: bus.rs1_address_i = e.addr;
        K_RD2:         bus.rs2_address_i = e.addr;
        K_RDY:         bus.rsv_address_i = e.addr;
        default: ;
      endcase
      #1;
      case (e.kind)
        K_RD1:   obs = bus.rs1_data_o;
        K_RD2:   obs = bus.rs2_data_o;
        K_BSY1:  obs = {31'd0, bus.rs1_busy_o};
        K_RDY:   obs = {31'd0, bus.rsv_ready_o};
        default: obs = 32'(bus.busy_count_o);
      endcase
      n_vec++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
    bus.rs1_address_i = s1; bus.rs2_address_i = s2; bus.rsv_address_i = sr;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.rs1_address_i = '0;
    bus.rs2_address_i = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    expect_v("rst_data_x5", K_RD1, 5, 32'h0);
    expect_v("rst_busy_x5", K_BSY1, 5, 32'h0);
    expect_v("rst_count", K_CNT, 0, 32'h0);
    expect_v("rst_ready_x7", K_RDY, 7, 32'h1);
    drain();

    // Port A write x5, latency, x0 stays zero.
    bus.rd_we_i = 1'b1; bus.rd_address_i = 5; bus.rd_data_i = 32'hDEADBEEF;
`ifdef REGFILE_BYPASS_EN
    expect_v("a_x5_same_cycle", K_RD1, 5, 32'hDEADBEEF);
`else
    expect_v("a_x5_same_cycle", K_RD1, 5, 32'h0);
`endif
    drain();
    tick();
    idle();
    expect_v("a_x5_next_cycle", K_RD1, 5, 32'hDEADBEEF);
    expect_v("rs2_x0_zero", K_RD2, 0, 32'h0);
    drain();
    bus.rd_we_i = 1'b1; bus.rd_address_i = 0; bus.rd_data_i = 32'h1234;
    tick();
    idle();
    expect_v("x0_write_ignored", K_RD1, 0, 32'h0);
    drain();

    // Reserve x7, re-reserve refused, release via port B.
    bus.rsv_valid_i = 1'b1; bus.rsv_address_i = 7;
    tick();
    idle();
    expect_v("rsv_x7_busy", K_BSY1, 7, 32'h1);
    expect_v("rsv_x7_count", K_CNT, 0, 32'h1);
    drain();
    bus.rsv_valid_i = 1'b1; bus.rsv_address_i = 7;
    expect_v("rsv_x7_again_ready", K_RDY, 7, 32'h0);
    drain();
    tick();
    idle();
    expect_v("rsv_x7_again_count", K_CNT, 0, 32'h1);
    drain();
    bus.lw_we_i = 1'b1; bus.lw_address_i = 7; bus.lw_data_i = 32'h55;
    tick();
    idle();
    expect_v("b_x7_busy_clear", K_BSY1, 7, 32'h0);
    expect_v("b_x7_data", K_RD1, 7, 32'h55);
    expect_v("b_x7_count", K_CNT, 0, 32'h0);
    drain();

    // Same-address collision: port B wins.
    bus.rd_we_i = 1'b1; bus.rd_address_i = 9; bus.rd_data_i = 32'h11;
    bus.lw_we_i = 1'b1; bus.lw_address_i = 9; bus.lw_data_i = 32'h22;
`ifdef REGFILE_BYPASS_EN
    expect_v("collide_x9_bypass", K_RD1, 9, 32'h22);
    drain();
`endif
    tick();
    idle();
    expect_v("collide_x9_data", K_RD1, 9, 32'h22);
    expect_v("collide_x9_count", K_CNT, 0, 32'h0);
    drain();

    // Three reservations, then release x3 while reserving x6.
    for (int r = 3; r <= 5; r++) begin
      bus.rsv_valid_i = 1'b1; bus.rsv_address_i = AW'(r);
      tick();
    end
    idle();
    expect_v("rsv_3_count", K_CNT, 0, 32'h3);
    drain();
    bus.lw_we_i = 1'b1; bus.lw_address_i = 3; bus.lw_data_i = 32'h33;
    bus.rsv_valid_i = 1'b1; bus.rsv_address_i = 6;
    tick();
    idle();
    expect_v("swap_count", K_CNT, 0, 32'h3);
    expect_v("swap_x3_busy", K_BSY1, 3, 32'h0);
    expect_v("swap_x6_busy", K_BSY1, 6, 32'h1);
    expect_v("swap_x4_busy", K_BSY1, 4, 32'h1);
    expect_v("swap_x3_data", K_RD1, 3, 32'h33);
    drain();

`ifdef REGFILE_BYPASS_EN
    // Release and re-reserve of x4 in one cycle: set wins.
    bus.lw_we_i = 1'b1; bus.lw_address_i = 4; bus.lw_data_i = 32'h44;
    bus.rsv_valid_i = 1'b1; bus.rsv_address_i = 4;
    expect_v("byp_x4_ready", K_RDY, 4, 32'h1);
    expect_v("byp_x4_busy_now", K_BSY1, 4, 32'h0);
    drain();
    tick();
    idle();
    expect_v("byp_x4_busy_after", K_BSY1, 4, 32'h1);
    expect_v("byp_x4_count", K_CNT, 0, 32'h3);
    drain();
`endif

    // Mid-operation reset.
    bus.rsv_valid_i = 1'b1; bus.rsv_address_i = 10;
    tick();
    bus.rsv_address_i = 11;
    bus.rd_we_i = 1'b1; bus.rd_address_i = 12; bus.rd_data_i = 32'hAA;
    tick();
    idle();
    expect_v("pre_rst_count", K_CNT, 0, 32'h5);
    expect_v("pre_rst_x12", K_RD1, 12, 32'hAA);
    drain();
    rst = 1'b1;
    bus.rd_we_i = 1'b1; bus.rd_address_i = 13; bus.rd_data_i = 32'hFF;
    bus.rsv_valid_i = 1'b1; bus.rsv_address_i = 14;
    tick();
    rst = 1'b0;
    idle();
    expect_v("mid_rst_x12", K_RD1, 12, 32'h0);
    expect_v("mid_rst_x5", K_RD1, 5, 32'h0);
    expect_v("mid_rst_x9", K_RD1, 9, 32'h0);
    expect_v("mid_rst_x13", K_RD1, 13, 32'h0);
    expect_v("mid_rst_busy_x10", K_BSY1, 10, 32'h0);
    expect_v("mid_rst_busy_x14", K_BSY1, 14, 32'h0);
    expect_v("mid_rst_count", K_CNT, 0, 32'h0);
    drain();
    bus.lw_we_i = 1'b1; bus.lw_address_i = 10; bus.lw_data_i = 32'h99;
    tick();
    idle();
    expect_v("post_rst_x10_data", K_RD1, 10, 32'h99);
    expect_v("post_rst_count", K_CNT, 0, 32'h0);
    expect_v("post_rst_x10_busy", K_BSY1, 10, 32'h0);
    drain();

    // Port B to a non-reserved register, reservation of x0.
    bus.rsv_valid_i = 1'b1; bus.rsv_address_i = 2;
    tick();
    idle();
    bus.lw_we_i = 1'b1; bus.lw_address_i = 8; bus.lw_data_i = 32'h77;
    tick();
    idle();
    expect_v("b_x8_data", K_RD1, 8, 32'h77);
    expect_v("b_x8_count", K_CNT, 0, 32'h1);
    drain();
    bus.rsv_valid_i = 1'b1; bus.rsv_address_i = 0;
    expect_v("rsv_x0_ready", K_RDY, 0, 32'h1);
    drain();
    tick();
    idle();
    expect_v("rsv_x0_count", K_CNT, 0, 32'h1);
    expect_v("rsv_x0_busy", K_BSY1, 0, 32'h0);
    expect_v("rsv_x2_busy", K_BSY1, 2, 32'h1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
